// File: rtl/i2s_tx_master_if.sv
// Sample-pair handshake between a PCM source and the I2S transmitter.
// The source drives a left/right pair with a valid flag. The transmitter
// answers with ready whenever its one-entry holding buffer is empty.
interface i2s_tx_master_if #(
  parameter int DATA_WIDTH = 16
);

  logic [DATA_WIDTH-1:0] i_left_data;
  logic [DATA_WIDTH-1:0] i_right_data;
  logic                  i_data_vld;
  logic                  o_data_rdy;

  modport master (
    output i_left_data,
    output i_right_data,
    output i_data_vld,
    input  o_data_rdy
  );

  modport slave (
    input  i_left_data,
    input  i_right_data,
    input  i_data_vld,
    output o_data_rdy
  );

endinterface

// File: rtl/i2s_tx_master.sv
// I2S transmit master, Philips format.
// SCK is derived from the system clock by dividing it by 2*CLK_DIV.
// A single frame is the left word followed by the right word, sent MSB first.
// WS changes one SCK ahead of each slot's MSB.
// One pair of samples can wait in a holding buffer while the current frame
// shifts out. The buffer is moved into the shifter at the frame boundary.
// If the buffer is empty at the boundary, a zero frame is sent and
// o_underrun pulses.
module i2s_tx_master #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_en,
  i2s_tx_master_if.slave        bus,
  output logic                  o_sck,
  output logic                  o_ws,
  output logic                  o_sd,
  output logic                  o_frame_start,
  output logic                  o_underrun
);

  localparam int SHIFT_W = 2 * DATA_WIDTH;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W   = $clog2(SHIFT_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_W - 1);
  // WS is high from the slot before the right MSB up to the slot before the
  // next left MSB.
  localparam logic [CNT_W-1:0] WS_FIRST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] WS_LAST  = CNT_W'(SHIFT_W - 2);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  sck_q, sck_d;
  logic                  ws_q, ws_d;
  logic                  sd_q, sd_d;
  logic [SHIFT_W-1:0]    shift_q, shift_d;
  logic [DATA_WIDTH-1:0] buf_left_q, buf_left_d;
  logic [DATA_WIDTH-1:0] buf_right_q, buf_right_d;
  logic                  buf_full_q, buf_full_d;
  logic                  frame_start_q, frame_start_d;
  logic                  underrun_q, underrun_d;
  logic                  accept;

  // The buffer can take a new pair whenever it is empty, including in IDLE.
  assign bus.o_data_rdy = ~buf_full_q;

  assign o_sck         = sck_q;
  assign o_ws          = ws_q;
  assign o_sd          = sd_q;
  assign o_frame_start = frame_start_q;
  assign o_underrun    = underrun_q;

  // Next-state logic: holding buffer, divider, SCK phase, bit counter and shifter.
  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    bit_cnt_d     = bit_cnt_q;
    sck_d         = sck_q;
    ws_d          = ws_q;
    sd_d          = sd_q;
    shift_d       = shift_q;
    buf_left_d    = buf_left_q;
    buf_right_d   = buf_right_q;
    buf_full_d    = buf_full_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    accept        = bus.i_data_vld & ~buf_full_q;

    if (accept) begin
      buf_left_d  = bus.i_left_data;
      buf_right_d = bus.i_right_data;
      buf_full_d  = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (i_en) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (sck_q) begin
            sck_d = 1'b0;
          end else if (bit_cnt_q == CNT_LAST) begin
            if (!i_en) begin
              state_d   = IDLE;
              bit_cnt_d = CNT_LAST;
              ws_d      = 1'b0;
              sd_d      = 1'b0;
            end else begin
              sck_d         = 1'b1;
              bit_cnt_d     = '0;
              frame_start_d = 1'b1;
              if (buf_full_q) begin
                shift_d    = {buf_left_q, buf_right_q};
                buf_full_d = 1'b0;
              end else begin
                shift_d    = '0;
                underrun_d = 1'b1;
              end
              sd_d = shift_d[SHIFT_W-1];
              ws_d = 1'b0;
            end
          end else begin
            sck_d     = 1'b1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = {shift_q[SHIFT_W-2:0], 1'b0};
            sd_d      = shift_d[SHIFT_W-1];
            ws_d      = (bit_cnt_d >= WS_FIRST) && (bit_cnt_d <= WS_LAST);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset parks everything in IDLE and drops any buffered pair.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q       <= IDLE;
      div_q         <= '0;
      bit_cnt_q     <= CNT_LAST;
      sck_q         <= 1'b0;
      ws_q          <= 1'b0;
      sd_q          <= 1'b0;
      shift_q       <= '0;
      buf_left_q    <= '0;
      buf_right_q   <= '0;
      buf_full_q    <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      bit_cnt_q     <= bit_cnt_d;
      sck_q         <= sck_d;
      ws_q          <= ws_d;
      sd_q          <= sd_d;
      shift_q       <= shift_d;
      buf_left_q    <= buf_left_d;
      buf_right_q   <= buf_right_d;
      buf_full_q    <= buf_full_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

endmodule

// File: doc/i2s_tx_master.md
I2S_TX_MASTER -- requirements
Module: i2s_tx_master

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving bits per channel slot and per parallel word.
REQ-002 The block SHALL have parameter CLK_DIV, default 4, giving system clocks per SCK half-period; legal range is 2 or more.
REQ-003 i_sys_clk  input  1  system clock; all logic SHALL be clocked on its rising edge, and this is the block's only clock.
REQ-004 i_sys_rst  input  1  reset, synchronous, active-high.
REQ-005 i_en  input  1  transmit enable.
REQ-006 i_left_data  input  DATA_WIDTH  left-channel sample, two's complement.
REQ-007 i_right_data  input  DATA_WIDTH  right-channel sample, two's complement.
REQ-008 i_data_vld  input  1  sample pair valid.
REQ-009 o_data_rdy  output  1  holding buffer empty; a transfer occurs when i_data_vld and o_data_rdy are both 1 on a clock edge.
REQ-010 o_sck  output  1  I2S serial clock.
REQ-011 o_ws  output  1  word select: 0 means left, 1 means right.
REQ-012 o_sd  output  1  serial data, MSB first.
REQ-013 o_frame_start  output  1  one-clock pulse when a frame is loaded into the shifter.
REQ-014 o_underrun  output  1  one-clock pulse when a frame starts with the holding buffer empty.

Function
REQ-015 State machine SHALL have two states, IDLE and RUN; IDLE SHALL go to RUN on the first clock with i_en=1.
REQ-016 In RUN, the divider SHALL count 0..CLK_DIV-1; at terminal count it SHALL wrap to 0 and o_sck SHALL toggle. SCK period is 2*CLK_DIV clocks and its first edge is rising.
REQ-017 A "rise event" is a terminal count while o_sck=0; o_sd, o_ws and the bit counter SHALL update only in that same clock, so all three change with the SCK rising edge and are stable on the falling edge.
REQ-018 The bit counter SHALL span 0..2*DATA_WIDTH-1, reset to 2*DATA_WIDTH-1, and increment with wrap on each rise event.
REQ-019 On the rise event where the bit counter wraps to 0 (the frame boundary), the shifter SHALL load {left, right} from the holding buffer, clear the buffer, and pulse o_frame_start.
REQ-020 If the buffer is empty at the frame boundary, the shifter SHALL load all zeros and o_underrun and o_frame_start SHALL both pulse; data accepted in that same clock SHALL go to the holding buffer for the next frame.
REQ-021 o_sd SHALL present shifter bit (2*DATA_WIDTH-1-bitcount): left MSB at count 0, right LSB at count 2*DATA_WIDTH-1.
REQ-022 o_ws SHALL be 1 for counts DATA_WIDTH-1..2*DATA_WIDTH-2 and 0 otherwise, so WS leads each slot's MSB by one SCK (Philips format).
REQ-023 o_data_rdy SHALL equal NOT holding-buffer-full, as a combinational function; the holding buffer is one entry.
REQ-024 If i_en=0 at a frame boundary, the block SHALL go to IDLE instead of loading; the in-flight frame always completes.
REQ-025 In IDLE the divider SHALL be 0, the bit counter SHALL be 2*DATA_WIDTH-1, and o_sck, o_ws, o_sd SHALL be 0; the holding buffer SHALL be retained and SHALL still accept data.
REQ-026 i_en toggling mid-frame SHALL have no effect before the frame boundary.

Reset
REQ-027 While i_sys_rst=1 on a clock edge, the block SHALL enter IDLE and clear the holding buffer; the divider and bit counter SHALL take their IDLE values.
REQ-028 Reset values: o_sck=0, o_ws=0, o_sd=0, o_frame_start=0, o_underrun=0, o_data_rdy=1.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, with no further SCK edges.

Verification
REQ-030 Defaults, i_en=1, one pair L=16'hA5C3, R=16'h0F01 offered before the first boundary: first rise at clock 4; o_frame_start pulses at clock 4; o_sd carries A5C3 then 0F01 MSB-first, one bit per 8 clocks; frame is 256 clocks.
REQ-031 Same run: o_ws rises on the SCK rise carrying L bit 0, falls on the SCK rise carrying R bit 0, and is 0 again at the next frame's MSB.
REQ-032 No data supplied: o_underrun and o_frame_start pulse at every boundary and o_sd stays 0; then supply 16'h8000/16'h0001 mid-frame: both are transmitted in the next frame with no underrun pulse.
REQ-033 Back-to-back: i_data_vld held high with new pairs: o_data_rdy is 0 from accept until the next boundary, one pair is consumed per 256 clocks, and no pairs are lost or duplicated.
REQ-034 i_en dropped at count 5 of a frame: frame completes, then o_sck, o_ws, o_sd are 0 from that boundary on; re-assert i_en: first rise 4 clocks later, starting a new frame.
REQ-035 Reset pulsed mid-frame with the buffer full: all outputs take REQ-028 values on the next clock, and o_data_rdy=1.
